uart_rtl_core: RTL and testbench

Byte-oriented 8N1 UART with a transmit FIFO and a receive FIFO, driven from a single system clock. It sits between on-chip logic and the serial pins. Logic pushes bytes with a one-cycle `transmit` strobe and pops received bytes with `rx_fifo_pop`. `irq` is a level interrupt that signals pending receive data.

---
 rtl/uart_rtl_core_if.sv | 28 ++
 rtl/uart_rtl_core.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_uart_rtl_core.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rtl_core_if.sv
// uart_rtl_core_if: on-chip side of the UART.
//   transmit      strobe, writes tx_byte into the TX FIFO
//   tx_byte       byte to queue for transmission
//   tx_fifo_full  TX FIFO holds FIFO_DEPTH entries
//   busy          TX FIFO non-empty or a frame on the line
//   rx_byte       RX FIFO head, first-word fall-through, 8'h00 when empty
//   rx_fifo_pop   strobe, removes the RX FIFO head
//   irq           RX FIFO non-empty
// master: the logic using the UART; slave: the UART core.
interface uart_rtl_core_if;
    logic       transmit;
    logic [7:0] tx_byte;
    logic       tx_fifo_full;
    logic       busy;
    logic [7:0] rx_byte;
    logic       rx_fifo_pop;
    logic       irq;

    modport master (
        output transmit, tx_byte, rx_fifo_pop,
        input  tx_fifo_full, busy, rx_byte, irq
    );

    modport slave (
        input  transmit, tx_byte, rx_fifo_pop,
        output tx_fifo_full, busy, rx_byte, irq
    );
endinterface

// File: rtl/uart_rtl_core.sv
// uart_rtl_core: 8N1 UART with TX and RX FIFOs on a single clock.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-low reset
//   rx   serial input, idles high
//   tx   serial output, idles high
//   bus  uart_rtl_core_if.slave (transmit/tx_byte/tx_fifo_full/busy/
//        rx_byte/rx_fifo_pop/irq)
// Build option: define UART_RTL_PARITY_EN to add an even-parity bit between
// data bit 7 and the stop bit (11-bit frames); RX drops bytes with bad parity.
module uart_rtl_core #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rx,
    output logic           tx,
    uart_rtl_core_if.slave bus
);
    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
    localparam int unsigned FCNT_W       = PTR_W + 1;

    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop, RxWait} rx_state_e;

    // ---------------------------------------------------------------- TX FIFO
    logic [7:0]        tx_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  tx_wr_q, tx_rd_q;
    logic [FCNT_W-1:0] tx_cnt_q;
    logic              tx_push, tx_pop, tx_nonempty;
    logic [7:0]        tx_head;

    assign tx_nonempty = (tx_cnt_q != '0);
    assign tx_push     = bus.transmit && (tx_cnt_q != FIFO_FULL);
    assign tx_head     = tx_mem_q[tx_rd_q];

    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem_q[tx_wr_q] <= bus.tx_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            tx_cnt_q <= '0;
        end else begin
            if (tx_push) tx_wr_q <= tx_wr_q + PTR_W'(1);
            if (tx_pop)  tx_rd_q <= tx_rd_q + PTR_W'(1);
            tx_cnt_q <= tx_cnt_q + FCNT_W'(tx_push) - FCNT_W'(tx_pop);
        end
    end

    // ----------------------------------------------------------------- TX FSM
    tx_state_e        tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_bit_cnt_q, tx_bit_cnt_d;
    logic [2:0]       tx_idx_q, tx_idx_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_q, tx_d;
    logic             tx_bit_end;

    assign tx_bit_end = (tx_bit_cnt_q == BIT_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_state_q   <= TxIdle;
            tx_bit_cnt_q <= '0;
            tx_idx_q     <= '0;
            tx_data_q    <= '0;
            tx_q         <= 1'b1;
        end else begin
            tx_state_q   <= tx_state_d;
            tx_bit_cnt_q <= tx_bit_cnt_d;
            tx_idx_q     <= tx_idx_d;
            tx_data_q    <= tx_data_d;
            tx_q         <= tx_d;
        end
    end

    always_comb begin
        tx_state_d   = tx_state_q;
        tx_bit_cnt_d = tx_bit_end ? '0 : tx_bit_cnt_q + CNT_W'(1);
        tx_idx_d     = tx_idx_q;
        tx_data_d    = tx_data_q;
        tx_d         = tx_q;
        tx_pop       = 1'b0;
        unique case (tx_state_q)
            TxIdle: begin
                tx_bit_cnt_d = '0;
                if (tx_nonempty) begin
                    tx_pop     = 1'b1;
                    tx_data_d  = tx_head;
                    tx_d       = 1'b0;
                    tx_state_d = TxStart;
                end
            end
            TxStart: begin
                if (tx_bit_end) begin
                    tx_idx_d   = '0;
                    tx_d       = tx_data_q[0];
                    tx_state_d = TxData;
                end
            end
            TxData: begin
                if (tx_bit_end) begin
                    if (tx_idx_q == 3'd7) begin
`ifdef UART_RTL_PARITY_EN
                        tx_d       = ^tx_data_q;
                        tx_state_d = TxParity;
`else
                        tx_d       = 1'b1;
                        tx_state_d = TxStop;
`endif
                    end else begin
                        tx_idx_d = tx_idx_q + 3'd1;
                        tx_d     = tx_data_q[tx_idx_q + 3'd1];
                    end
                end
            end
            TxParity: begin
                if (tx_bit_end) begin
                    tx_d       = 1'b1;
                    tx_state_d = TxStop;
                end
            end
            TxStop: begin
                if (tx_bit_end) begin
                    // Chain straight into the next start bit: no idle gap.
                    if (tx_nonempty) begin
                        tx_pop     = 1'b1;
                        tx_data_d  = tx_head;
                        tx_d       = 1'b0;
                        tx_state_d = TxStart;
                    end else begin
                        tx_state_d = TxIdle;
                    end
                end
            end
            default: begin
                tx_d       = 1'b1;
                tx_state_d = TxIdle;
            end
        endcase
    end

    // ----------------------------------------------------------------- RX FSM
    logic             rx_s1_q, rx_s2_q, rx_prev_q;
    rx_state_e        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_bit_cnt_q, rx_bit_cnt_d;
    logic [2:0]       rx_idx_q, rx_idx_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic             rx_par_ok_q, rx_par_ok_d;
    logic             rx_push, rx_bit_end;

    assign rx_bit_end = (rx_bit_cnt_q == BIT_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_s1_q      <= 1'b1;
            rx_s2_q      <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_state_q   <= RxIdle;
            rx_bit_cnt_q <= '0;
            rx_idx_q     <= '0;
            rx_shift_q   <= '0;
            rx_par_ok_q  <= 1'b1;
        end else begin
            rx_s1_q      <= rx;
            rx_s2_q      <= rx_s1_q;
            rx_prev_q    <= rx_s2_q;
            rx_state_q   <= rx_state_d;
            rx_bit_cnt_q <= rx_bit_cnt_d;
            rx_idx_q     <= rx_idx_d;
            rx_shift_q   <= rx_shift_d;
            rx_par_ok_q  <= rx_par_ok_d;
        end
    end

    always_comb begin
        rx_state_d   = rx_state_q;
        rx_bit_cnt_d = rx_bit_cnt_q + CNT_W'(1);
        rx_idx_d     = rx_idx_q;
        rx_shift_d   = rx_shift_q;
        rx_par_ok_d  = rx_par_ok_q;
        rx_push      = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                rx_bit_cnt_d = '0;
                if (rx_prev_q && !rx_s2_q) rx_state_d = RxStart;
            end
            RxStart: begin
                // Half a bit in: still low means a real start bit.
                if (rx_bit_cnt_q == HALF_LAST) begin
                    rx_bit_cnt_d = '0;
                    rx_idx_d     = '0;
                    rx_par_ok_d  = 1'b1;
                    rx_state_d   = rx_s2_q ? RxIdle : RxData;
                end
            end
            RxData: begin
                if (rx_bit_end) begin
                    rx_bit_cnt_d = '0;
                    rx_shift_d   = {rx_s2_q, rx_shift_q[7:1]};
                    if (rx_idx_q == 3'd7) begin
`ifdef UART_RTL_PARITY_EN
                        rx_state_d = RxParity;
`else
                        rx_state_d = RxStop;
`endif
                    end else begin
                        rx_idx_d = rx_idx_q + 3'd1;
                    end
                end
            end
            RxParity: begin
                if (rx_bit_end) begin
                    rx_bit_cnt_d = '0;
                    rx_par_ok_d  = (rx_s2_q == ^rx_shift_q);
                    rx_state_d   = RxStop;
                end
            end
            RxStop: begin
                if (rx_bit_end) begin
                    rx_bit_cnt_d = '0;
                    if (rx_s2_q && rx_par_ok_q) begin
                        rx_push    = 1'b1;
                        rx_state_d = RxIdle;
                    end else begin
                        rx_state_d = RxWait;
                    end
                end
            end
            RxWait: begin
                // Bad frame: hold off until the line returns high.
                rx_bit_cnt_d = '0;
                if (rx_s2_q) rx_state_d = RxIdle;
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    // ---------------------------------------------------------------- RX FIFO
    logic [7:0]        rx_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  rx_wr_q, rx_rd_q;
    logic [FCNT_W-1:0] rx_cnt_q;
    logic              rx_pop_ok, rx_push_ok, rx_nonempty;

    assign rx_nonempty = (rx_cnt_q != '0);
    assign rx_pop_ok   = bus.rx_fifo_pop && rx_nonempty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign rx_push_ok  = rx_push && ((rx_cnt_q != FIFO_FULL) || rx_pop_ok);

    always_ff @(posedge clk) begin
        if (rx_push_ok) begin
            rx_mem_q[rx_wr_q] <= rx_shift_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_cnt_q <= '0;
        end else begin
            if (rx_push_ok) rx_wr_q <= rx_wr_q + PTR_W'(1);
            if (rx_pop_ok)  rx_rd_q <= rx_rd_q + PTR_W'(1);
            rx_cnt_q <= rx_cnt_q + FCNT_W'(rx_push_ok) - FCNT_W'(rx_pop_ok);
        end
    end

    // ---------------------------------------------------------------- Outputs
    assign tx               = tx_q;
    assign bus.busy         = tx_nonempty || (tx_state_q != TxIdle);
    assign bus.tx_fifo_full = (tx_cnt_q == FIFO_FULL);
    assign bus.irq          = rx_nonempty;
    assign bus.rx_byte      = rx_nonempty ? rx_mem_q[rx_rd_q] : 8'h00;

endmodule

// File: tb/tb_uart_rtl_core.sv
// tb_uart_rtl_core: randomized self-checking bench for uart_rtl_core.
// A remote UART is modelled behaviourally: a bit-banging sender on rx, a
// frame decoder on tx, and a queue standing in for the RX FIFO contents.
// A fast baud rate (20 clocks per bit) keeps the run short.
`timescale 1ns/1ps
module tb_uart_rtl_core;
    localparam int unsigned CLK_FREQ = 50_000_000;
    localparam int unsigned BAUD     = 2_500_000;
    localparam int unsigned CPB      = CLK_FREQ / BAUD;
    localparam int unsigned DEPTH    = 16;
`ifdef UART_RTL_PARITY_EN
    localparam int unsigned FB = 11;
`else
    localparam int unsigned FB = 10;
`endif

    logic clk_tb   = 1'b0;
    logic reset_tb = 1'b0;
    logic rx       = 1'b1;
    logic tx;

    uart_rtl_core_if bus ();

    uart_rtl_core #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk (clk_tb),
        .rst (reset_tb),
        .rx  (rx),
        .tx  (tx),
        .bus (bus)
    );

    always #5 clk_tb = ~clk_tb;

    int unsigned cyc = 0;
    always @(posedge clk_tb) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic [7:0]  mon_q[$];
    int unsigned mon_start[$];
    int          mon_bad = 0;
    logic [7:0]  rx_model[$];

    // Remote receiver: decodes frames on tx, sampling mid-bit.
    logic       mon_prev = 1'b1;
    logic [7:0] mon_b;
    logic       mon_ok;
    initial begin
        forever begin
            @(negedge clk_tb);
            if (mon_prev === 1'b1 && tx === 1'b0) begin
                mon_start.push_back(cyc);
                repeat (CPB / 2) @(negedge clk_tb);
                mon_ok = (tx === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk_tb);
                    mon_b[i] = tx;
                end
`ifdef UART_RTL_PARITY_EN
                repeat (CPB) @(negedge clk_tb);
                if (tx !== ^mon_b) mon_ok = 1'b0;
`endif
                repeat (CPB) @(negedge clk_tb);
                if (tx !== 1'b1) mon_ok = 1'b0;
                mon_q.push_back(mon_b);
                if (!mon_ok) mon_bad++;
            end
            mon_prev = tx;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_tb);
        #1;
    endtask

    task automatic wait_until(input int unsigned t);
        while (cyc < t) tick();
    endtask

    task automatic mon_clear();
        mon_q.delete();
        mon_start.delete();
        mon_bad = 0;
    endtask

    task automatic wait_mon(input int n, input int unsigned budget, input string name);
        int unsigned t = 0;
        while (mon_q.size() < n && t < budget) begin
            tick();
            t++;
        end
        checks++;
        if (mon_q.size() < n) begin
            errors++;
            $display("FAIL %s: remote got %0d frames, expected %0d", name, mon_q.size(), n);
        end
    endtask

    // Remote sender: one frame on rx; good frames enter the FIFO model.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) tick();
        end
`ifdef UART_RTL_PARITY_EN
        rx = ^b;
        repeat (CPB) tick();
`endif
        rx = stop_bit;
        repeat (CPB) tick();
        if (stop_bit) begin
            if (rx_model.size() < DEPTH) rx_model.push_back(b);
        end else begin
            rx = 1'b1;
            repeat (2 * CPB) tick();
        end
    endtask

    task automatic do_pop();
        bus.rx_fifo_pop = 1'b1;
        tick();
        bus.rx_fifo_pop = 1'b0;
        if (rx_model.size() > 0) void'(rx_model.pop_front());
    endtask

    function automatic logic [7:0] model_head();
        return (rx_model.size() > 0) ? rx_model[0] : 8'h00;
    endfunction

    task automatic check_rx_side(input string name);
        logic [7:0] exp_b;
        logic       exp_i;
        exp_b = model_head();
        exp_i = (rx_model.size() > 0);
        checks++;
        if (bus.rx_byte !== exp_b) begin
            errors++;
            $display("FAIL %s rx_byte: got %h expected %h", name, bus.rx_byte, exp_b);
        end
        checks++;
        if (bus.irq !== exp_i) begin
            errors++;
            $display("FAIL %s irq: got %b expected %b", name, bus.irq, exp_i);
        end
    endtask

    task automatic test_reset();
        reset_tb        = 1'b0;
        rx              = 1'b1;
        bus.transmit    = 1'b0;
        bus.tx_byte     = 8'h00;
        bus.rx_fifo_pop = 1'b0;
        repeat (10) tick();
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset tx: got %b expected 1", tx); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", bus.busy); end
        checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL reset irq: got %b expected 0", bus.irq); end
        checks++; if (bus.tx_fifo_full !== 1'b0) begin errors++; $display("FAIL reset full: got %b expected 0", bus.tx_fifo_full); end
        checks++; if (bus.rx_byte !== 8'h00) begin errors++; $display("FAIL reset rx_byte: got %h expected 00", bus.rx_byte); end
        reset_tb = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_single_tx();
        logic [7:0]  b = 8'h41;
        logic        exp;
        int unsigned t0;
        mon_clear();
        bus.tx_byte  = b;
        bus.transmit = 1'b1;
        tick();
        bus.transmit = 1'b0;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single busy rise: got %b expected 1", bus.busy); end
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL single tx early: got %b expected 1", tx); end
        tick();
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL single start bit: got %b expected 0", tx); end
        t0 = cyc;
        for (int i = 0; i < FB; i++) begin
            if (i == 0)                  exp = 1'b0;
            else if (i <= 8)             exp = b[i-1];
            else if (i == 9 && FB == 11) exp = ^b;
            else                         exp = 1'b1;
            wait_until(t0 + i * CPB + CPB / 2);
            checks++;
            if (tx !== exp) begin
                errors++;
                $display("FAIL single bit %0d: got %b expected %b", i, tx, exp);
            end
        end
        wait_until(t0 + FB * CPB - 1);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single busy hold: got %b expected 1", bus.busy); end
        tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single busy fall: got %b expected 0", bus.busy); end
        wait_mon(1, 4 * CPB, "single frames");
        checks++;
        if (mon_q.size() < 1 || mon_q[0] !== b || mon_bad != 0) begin
            errors++;
            $display("FAIL single remote byte: got %h (bad %0d) expected %h",
                     (mon_q.size() > 0) ? mon_q[0] : 8'hxx, mon_bad, b);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q[$];
        logic [7:0] got;
        mon_clear();
        exp_q = '{8'h41, 8'h42, 8'h43};
        exp_q.push_back(8'($urandom));
        exp_q.push_back(8'($urandom));
        bus.transmit = 1'b1;
        foreach (exp_q[i]) begin
            bus.tx_byte = exp_q[i];
            tick();
        end
        bus.transmit = 1'b0;
        wait_mon(exp_q.size(), exp_q.size() * FB * CPB + 100, "b2b frames");
        foreach (exp_q[i]) begin
            got = (i < mon_q.size()) ? mon_q[i] : 8'hxx;
            checks++;
            if (got !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b byte %0d: got %h expected %h", i, got, exp_q[i]);
            end
        end
        for (int i = 1; i < mon_start.size(); i++) begin
            checks++;
            if (mon_start[i] - mon_start[i-1] != FB * CPB) begin
                errors++;
                $display("FAIL b2b spacing %0d: got %0d cycles expected %0d", i,
                         mon_start[i] - mon_start[i-1], FB * CPB);
            end
        end
        checks++; if (mon_bad != 0) begin errors++; $display("FAIL b2b framing: got %0d bad expected 0", mon_bad); end
        repeat (CPB) tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_tx_full();
        logic [7:0] bytes[18];
        logic [7:0] got;
        mon_clear();
        foreach (bytes[i]) bytes[i] = 8'($urandom);
        bus.transmit = 1'b1;
        for (int i = 0; i < 18; i++) begin
            bus.tx_byte = bytes[i];
            tick();
            if (i == 15) begin
                checks++;
                if (bus.tx_fifo_full !== 1'b0) begin errors++; $display("FAIL full early: got %b expected 0", bus.tx_fifo_full); end
            end
            if (i == 16) begin
                checks++;
                if (bus.tx_fifo_full !== 1'b1) begin errors++; $display("FAIL full set: got %b expected 1", bus.tx_fifo_full); end
            end
        end
        bus.transmit = 1'b0;
        checks++; if (bus.tx_fifo_full !== 1'b1) begin errors++; $display("FAIL full hold: got %b expected 1", bus.tx_fifo_full); end
        wait_mon(17, 17 * FB * CPB + 200, "full frames");
        repeat (2 * FB * CPB) tick();
        checks++; if (mon_q.size() != 17) begin errors++; $display("FAIL full count: got %0d expected 17", mon_q.size()); end
        for (int i = 0; i < 17; i++) begin
            got = (i < mon_q.size()) ? mon_q[i] : 8'hxx;
            checks++;
            if (got !== bytes[i]) begin
                errors++;
                $display("FAIL full byte %0d: got %h expected %h", i, got, bytes[i]);
            end
        end
        checks++; if (bus.tx_fifo_full !== 1'b0) begin errors++; $display("FAIL full clear: got %b expected 0", bus.tx_fifo_full); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL full busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_rx_pop();
        rx_model.delete();
        send_frame(8'h58, 1'b1);
        check_rx_side("rx first");
        send_frame(8'h59, 1'b1);
        send_frame(8'h5A, 1'b1);
        check_rx_side("rx three");
        for (int i = 0; i < 3; i++) begin
            do_pop();
            check_rx_side("rx pop");
        end
        do_pop();
        check_rx_side("rx pop empty");
    endtask

    task automatic test_rx_overflow();
        for (int i = 0; i < 17; i++) send_frame(8'($urandom), 1'b1);
        check_rx_side("ovf full");
        for (int i = 0; i < DEPTH; i++) begin
            do_pop();
            check_rx_side("ovf drain");
        end
        send_frame(8'($urandom), 1'b0);
        check_rx_side("framing empty");
        send_frame(8'($urandom), 1'b1);
        send_frame(8'($urandom), 1'b0);
        check_rx_side("framing nonempty");
        send_frame(8'($urandom), 1'b1);
        check_rx_side("after framing");
        do_pop();
        do_pop();
        check_rx_side("framing drain");
    endtask

    task automatic test_reset_midframe();
        send_frame(8'($urandom), 1'b1);
        check_rx_side("midrst prefill");
        bus.tx_byte  = 8'h00;
        bus.transmit = 1'b1;
        tick();
        bus.transmit = 1'b0;
        repeat (3 * CPB + CPB / 2) tick();
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL midrst data bit: got %b expected 0", tx); end
        reset_tb = 1'b0;
        tick();
        rx_model.delete();
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL midrst tx: got %b expected 1", tx); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst busy: got %b expected 0", bus.busy); end
        check_rx_side("midrst");
        reset_tb = 1'b1;
        repeat (FB * CPB + CPB) tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst idle: got %b expected 0", bus.busy); end
        mon_clear();
    endtask

    initial begin
        test_reset();
        test_single_tx();
        test_back_to_back();
        test_tx_full();
        test_rx_pop();
        test_rx_overflow();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
